// File: rtl/host_mem_loader_pkg.sv
// Shared opcodes, core-port command encodings and FSM states for the host loader.
package host_mem_loader_pkg;

  localparam logic [2:0] OP_WR_IMEM = 3'd0;
  localparam logic [2:0] OP_WR_DMEM = 3'd1;
  localparam logic [2:0] OP_RD_REG  = 3'd2;
  localparam logic [2:0] OP_RD_DMEM = 3'd3;
  localparam logic [2:0] OP_RUN     = 3'd4;

  // DRD doubles as the idle encoding: no write enable is active.
  localparam logic [1:0] CPU_CMD_REG = 2'b00;
  localparam logic [1:0] CPU_CMD_IWR = 2'b01;
  localparam logic [1:0] CPU_CMD_DRD = 2'b10;
  localparam logic [1:0] CPU_CMD_DWR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RUN,
    ST_RESP
  } state_t;

endpackage

// File: rtl/host_mem_loader_if.sv
// Host command/response channel plus the core debug/load port.
// master = the loader, slave = host and core side.
interface host_mem_loader_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        run_abort;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        cpu_reset;
  logic [1:0]  cpu_cmd;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data;
  logic [31:0] cpu_data_out;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, run_abort, rsp_ready, cpu_data_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, cpu_reset, cpu_cmd, cpu_addr, cpu_data
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, run_abort, rsp_ready, cpu_data_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, cpu_reset, cpu_cmd, cpu_addr, cpu_data
  );

endinterface

// File: rtl/host_mem_loader_run_counter.sv
// Clear/enable up-counter with a terminal-count compare; times both RUN and the read wait.
module host_mem_loader_run_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/host_mem_loader.sv
// Sequences the core's debug/load port and reset from one host command at a time,
// returning exactly one response per command.
module host_mem_loader
  import host_mem_loader_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  host_mem_loader_if.master bus
);

  state_t           state_q, state_d;
  logic [1:0]       cpu_cmd_q, cpu_cmd_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic [31:0]      cpu_addr_q, cpu_addr_d;
  logic [31:0]      cpu_data_q, cpu_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] term_q, term_d;

  logic             accept;
  logic             run_done;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] run_len;
  logic             tc;

  assign accept   = bus.cmd_valid && (state_q == ST_IDLE);
  assign run_len  = bus.cmd_data[CNT_W-1:0];
  assign run_done = (state_q == ST_RUN) && (tc || bus.run_abort);

  // Terminal value is len-1 for RUN and RD_LAT-1 for READ, so tc marks the last cycle.
  host_mem_loader_run_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (accept),
    .en_i   ((state_q == ST_READ) || (state_q == ST_RUN)),
    .term_i (term_q),
    .cnt_o  (cnt),
    .tc_o   (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_WR_IMEM, OP_WR_DMEM: state_d = ST_WRITE;
            OP_RD_REG,  OP_RD_DMEM: state_d = ST_READ;
            OP_RUN:                 state_d = (run_len == '0) ? ST_RESP : ST_RUN;
            default:                state_d = ST_RESP;
          endcase
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_READ:  if (tc) state_d = ST_RESP;
      ST_RUN:   if (run_done) state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_cmd_d   = cpu_cmd_q;
    cpu_reset_d = cpu_reset_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_data_d  = cpu_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    term_d      = term_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cpu_addr_d = bus.cmd_addr;
          cpu_data_d = bus.cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          term_d     = (bus.cmd_op == OP_RUN) ? (run_len - CNT_W'(1)) : CNT_W'(RD_LAT - 1);
          case (bus.cmd_op)
            OP_WR_IMEM: cpu_cmd_d = CPU_CMD_IWR;
            OP_WR_DMEM: cpu_cmd_d = CPU_CMD_DWR;
            OP_RD_REG:  cpu_cmd_d = CPU_CMD_REG;
            OP_RD_DMEM: cpu_cmd_d = CPU_CMD_DRD;
            OP_RUN: begin
              if (run_len != '0)
                cpu_reset_d = 1'b0;
              else
                rsp_valid_d = 1'b1;
            end
            default: begin
              rsp_err_d   = 1'b1;
              rsp_valid_d = 1'b1;
            end
          endcase
        end
      end
      ST_WRITE: begin
        cpu_cmd_d   = CPU_CMD_DRD;
        rsp_data_d  = '0;
        rsp_valid_d = 1'b1;
      end
      ST_READ: begin
        if (tc) begin
          cpu_cmd_d   = CPU_CMD_DRD;
          rsp_data_d  = bus.cpu_data_out;
          rsp_valid_d = 1'b1;
        end
      end
      ST_RUN: begin
        // The cycle ending at this edge still ran, hence cnt+1 executed cycles.
        if (run_done) begin
          cpu_reset_d = 1'b1;
          rsp_data_d  = 32'(cnt + CNT_W'(1));
          rsp_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_cmd_q   <= CPU_CMD_DRD;
      cpu_reset_q <= 1'b1;
      cpu_addr_q  <= '0;
      cpu_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      term_q      <= '0;
    end else begin
      cpu_cmd_q   <= cpu_cmd_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_data_q  <= cpu_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      term_q      <= term_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.cpu_cmd   = cpu_cmd_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.cpu_addr  = cpu_addr_q;
  assign bus.cpu_data  = cpu_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_host_mem_loader.sv
// Bench for host_mem_loader with a tiny ADDI-only core and 1-cycle BRAM as the load target.
module tb_host_mem_loader;
  import host_mem_loader_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  host_mem_loader_if bus();

  host_mem_loader #(.RD_LAT(2), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Core model: memories written through the load port, ADDI-only execution while out of reset.
  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:1023];
  logic [31:0] regs [0:31];
  logic [31:0] bram_q = '0;
  logic [31:0] pc = '0;
  logic [31:0] instr;

  assign instr            = imem[pc[11:2]];
  assign bus.cpu_data_out = (bus.cpu_cmd == CPU_CMD_REG) ? regs[bus.cpu_addr[4:0]] : bram_q;

  always @(posedge clk) begin
    if (bus.cpu_cmd == CPU_CMD_IWR) imem[bus.cpu_addr[11:2]] <= bus.cpu_data;
    if (bus.cpu_cmd == CPU_CMD_DWR) dmem[bus.cpu_addr[11:2]] <= bus.cpu_data;
    bram_q <= dmem[bus.cpu_addr[11:2]];
    if (bus.cpu_reset) begin
      pc <= '0;
    end else begin
      pc <= pc + 32'd4;
      if (instr[6:0] == 7'h13 && instr[14:12] == 3'd0 && instr[11:7] != 5'd0)
        regs[instr[11:7]] <= regs[instr[19:15]] + {{20{instr[31]}}, instr[31:20]};
    end
  end

  // Port activity monitor.
  int          low_cycles = 0;
  int          wr_pulses = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [1:0]  last_wr_cmd = '0;

  always @(posedge clk) begin
    if (!reset) begin
      if (!bus.cpu_reset) low_cycles++;
      if (bus.cpu_cmd == CPU_CMD_IWR || bus.cpu_cmd == CPU_CMD_DWR) begin
        wr_pulses++;
        last_wr_addr = bus.cpu_addr;
        last_wr_data = bus.cpu_data;
        last_wr_cmd  = bus.cpu_cmd;
      end
    end
  end

  // Reference state: what the host believes memory and registers hold.
  logic [31:0] shadow_dmem [0:1023];
  logic [31:0] exp_regs [0:31];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one command (caller is at a negedge) and checks the response against the model.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input int abort_at, input int stall);
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lows, exp_wrs, n, k, low0, wr0;
    logic [31:0] r_data;
    logic        r_err;
    exp_data = '0; exp_err = 1'b0; exp_lows = 0; exp_wrs = 0;
    case (op)
      OP_WR_IMEM: exp_wrs = 1;
      OP_WR_DMEM: begin exp_wrs = 1; shadow_dmem[addr[11:2]] = data; end
      OP_RD_REG:  exp_data = exp_regs[addr[4:0]];
      OP_RD_DMEM: exp_data = shadow_dmem[addr[11:2]];
      OP_RUN: begin
        exp_lows = (abort_at > 0 && abort_at <= int'(data)) ? abort_at : int'(data);
        exp_data = 32'(exp_lows);
      end
      default: exp_err = 1'b1;
    endcase
    low0 = low_cycles; wr0 = wr_pulses;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_data = data;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_in_time", 32'(n < 50), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 0; n = 0;
    while (n < 3000) begin
      if (!bus.cpu_reset) k++;
      bus.run_abort = (abort_at != 0 && k == abort_at && !bus.cpu_reset);
      if (bus.rsp_valid) break;
      @(negedge clk); n++;
    end
    bus.run_abort = 1'b0;
    check("rsp_in_time", 32'(n < 3000), 32'd1);
    r_data = bus.rsp_data; r_err = bus.rsp_err;
    check("rsp_data", r_data, exp_data);
    check("rsp_err", 32'(r_err), 32'(exp_err));
    // Stall: a pending command must not be acknowledged and the response must not move.
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_WR_DMEM; bus.cmd_addr = 32'h0; bus.cmd_data = 32'hFFFF_FFFF;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_data", bus.rsp_data, r_data);
      check("stall_ready_low", 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    check("ready_again", 32'(bus.cmd_ready), 32'd1);
    check("cpu_reset_high", 32'(bus.cpu_reset), 32'd1);
    check("low_cycles", 32'(low_cycles - low0), 32'(exp_lows));
    check("write_pulses", 32'(wr_pulses - wr0), 32'(exp_wrs));
    if (exp_wrs == 1) begin
      check("wr_addr", last_wr_addr, addr);
      check("wr_data", last_wr_data, data);
      check("wr_cmd", 32'(last_wr_cmd), (op == OP_WR_IMEM) ? 32'(CPU_CMD_IWR) : 32'(CPU_CMD_DWR));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin imem[i] = '0; dmem[i] = '0; shadow_dmem[i] = '0; end
    for (int i = 0; i < 32; i++) begin regs[i] = '0; exp_regs[i] = '0; end
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.run_abort = 1'b0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("rst_cpu_cmd", 32'(bus.cpu_cmd), 32'(CPU_CMD_DRD));
    check("rst_cpu_addr", bus.cpu_addr, 32'h0);
    check("rst_cpu_data", bus.cpu_data, 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    issue(OP_WR_IMEM, 32'h8, 32'h0050_0093, 0, 0);
    issue(OP_RUN, 32'h0, 32'd1, 0, 0);
    issue(OP_WR_DMEM, 32'h10, 32'hDEAD_BEEF, 0, 0);
    issue(OP_RD_DMEM, 32'h10, 32'h0, 0, 0);
    issue(OP_WR_IMEM, 32'h0, 32'h0050_0093, 0, 0);
    issue(OP_RUN, 32'h0, 32'd20, 0, 0);
    exp_regs[1] = 32'd5;  // addi x1, x0, 5 has now executed
    issue(OP_RD_REG, 32'h1, 32'h0, 0, 0);
    issue(OP_RUN, 32'h0, 32'd1000, 37, 0);
    issue(3'd6, 32'h40, 32'h1234, 0, 5);
    issue(OP_RUN, 32'h0, 32'd0, 0, 5);

    // Asynchronous reset in the middle of a run.
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_RUN; bus.cmd_addr = '0; bus.cmd_data = 32'd1000;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun_low", 32'(bus.cpu_reset), 32'd0);
    reset = 1'b1;
    #1;
    check("arst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_cpu_cmd", 32'(bus.cpu_cmd), 32'(CPU_CMD_DRD));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_arst_ready", 32'(bus.cmd_ready), 32'd1);
      check("post_arst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check("post_arst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    end

    // Randomized mix scored against the host-side model.
    for (int it = 0; it < 40; it++) begin
      int          kind;
      int          n_run;
      logic [31:0] a;
      kind = int'($urandom_range(0, 4));
      a = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
      case (kind)
        0: issue(OP_WR_DMEM, a, $urandom, 0, int'($urandom_range(0, 2)));
        1: issue(OP_RD_DMEM, a, 32'h0, 0, int'($urandom_range(0, 2)));
        2: begin
          n_run = int'($urandom_range(0, 40));
          issue(OP_RUN, 32'h0, 32'(n_run),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 45)) : 0, 0);
        end
        3: issue(OP_RD_REG, {27'h0, 5'($urandom_range(0, 31))}, 32'h0, 0, 0);
        default: issue(3'($urandom_range(5, 7)), a, $urandom, 0, int'($urandom_range(0, 3)));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
